// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shift/rotate unit moving at most STEP bits per clock.
module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [SHW-1:0]   b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] out_o
);
  localparam logic [2:0] SLL = 3'b000;
  localparam logic [2:0] SRL = 3'b001;
  localparam logic [2:0] SRA = 3'b010;
  localparam logic [2:0] ROL = 3'b011;
  localparam logic [2:0] ROR = 3'b100;
  localparam logic [SHW-1:0] STEP_W = SHW'(STEP);
  logic [WIDTH-1:0] w_q, w_d, out_q, out_d, sra, rol, ror, shifted;
  logic [SHW-1:0]   r_q, r_d, s;
  logic [SHW:0]     inv;
  logic [2:0]       op_q, op_d;
  logic             busy_q, busy_d, done_q, done_d;
  always_comb begin
    s       = (r_q < STEP_W) ? r_q : STEP_W;
    // s=0 makes inv equal WIDTH, so the wrap-around term vanishes
    inv     = (SHW+1)'(WIDTH) - (SHW+1)'(s);
    sra     = $signed(w_q) >>> s;
    rol     = (w_q << s) | (w_q >> inv);
    ror     = (w_q >> s) | (w_q << inv);
    shifted = (op_q == SLL) ? w_q << s :
              (op_q == SRL) ? w_q >> s :
              (op_q == SRA) ? sra :
              (op_q == ROL) ? rol :
              (op_q == ROR) ? ror : w_q;
    w_d     = w_q;
    r_d     = r_q;
    op_d    = op_q;
    busy_d  = busy_q;
    out_d   = out_q;
    done_d  = 1'b0;
    if (!busy_q) begin
      if (start_i) begin
        w_d    = a_i;
        r_d    = b_i;
        op_d   = op_i;
        busy_d = 1'b1;
      end
    end else if (r_q != '0) begin
      w_d = shifted;
      r_d = r_q - s;
    end else begin
      out_d  = w_q;
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q    <= '0;
      r_q    <= '0;
      op_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      out_q  <= '0;
    end else begin
      w_q    <= w_d;
      r_q    <= r_d;
      op_q   <= op_d;
      busy_q <= busy_d;
      done_q <= done_d;
      out_q  <= out_d;
    end
  end
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign out_o  = out_q;
endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: scoreboard bench over four step sizes of iter_shifter.
module tb_iter_shifter;
  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  start = '0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [4:0]  b = '0;
  logic [3:0]  busy, done;
  logic [31:0] out_w [4];
  exp_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    iter_shifter #(.WIDTH(32), .SHW(5), .STEP(g == 0 ? 4 : g == 1 ? 1 : g == 2 ? 3 : 31)) u_dut (
      .clk(clk), .rst(rst), .start_i(start[g]), .op_i(op), .a_i(a), .b_i(b),
      .busy_o(busy[g]), .done_o(done[g]), .out_o(out_w[g])
    );
  end
  function automatic int step_of(input int d);
    return d == 0 ? 4 : d == 1 ? 1 : d == 2 ? 3 : 31;
  endfunction
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [4:0] n);
    logic signed [31:0] sx;
    sx = x;
    case (o)
      3'd0: return x << n;
      3'd1: return x >> n;
      3'd2: return sx >>> n;
      3'd3: return n == 0 ? x : (x << n) | (x >> (32 - int'(n)));
      3'd4: return n == 0 ? x : (x >> n) | (x << (32 - int'(n)));
      default: return x;
    endcase
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic wait_done(input int d, input string tag);
    int   lat;
    logic bad_busy;
    exp_t e;
    lat = 0;
    bad_busy = 1'b0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!done[d] && !busy[d]) bad_busy = 1'b1;
    end while (!done[d] && lat < 60);
    if (!done[d]) check({tag, "_timeout"}, 32'd1, 32'd0);
    e = sb.pop_front();
    check({tag, "_out"}, out_w[d], e.res);
    check({tag, "_lat"}, lat, e.lat);
    check({tag, "_busy_hi"}, {31'd0, bad_busy}, 32'd0);
    check({tag, "_busy_lo"}, {31'd0, busy[d]}, 32'd0);
  endtask
  task automatic run_op(input int d, input logic [2:0] o, input logic [31:0] x, input logic [4:0] n,
                        input logic [31:0] res, input int lat, input string tag);
    @(negedge clk);
    start[d] = 1'b1;
    op = o;
    a = x;
    b = n;
    sb.push_back('{res, lat});
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    wait_done(d, tag);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {31'd0, done[d]}, 32'd0);
  endtask
  initial begin
    logic seen;
    #2;
    check("rst_busy", {31'd0, busy[0]}, 32'd0);
    check("rst_done", {31'd0, done[0]}, 32'd0);
    check("rst_out", out_w[0], 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_op(0, 3'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 9, "sll31");
    @(negedge clk);
    start[0] = 1'b1;
    op = 3'd0;
    a = 32'h1;
    b = 5'd31;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy[0]}, 32'd0);
    check("abort_done", {31'd0, done[0]}, 32'd0);
    check("abort_out", out_w[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done[0] || busy[0]) seen = 1'b1;
    end
    check("abort_quiet", {31'd0, seen}, 32'd0);
    run_op(0, 3'd2, 32'h8000_0000, 5'd4, 32'hF800_0000, 2, "sra4");
    run_op(0, 3'd1, 32'h8000_0000, 5'd4, 32'h0800_0000, 2, "srl4");
    run_op(0, 3'd4, 32'h0000_00F1, 5'd4, 32'h1000_000F, 2, "ror4");
    run_op(0, 3'd3, 32'h8000_0001, 5'd1, 32'h0000_0003, 2, "rol1");
    @(negedge clk);
    start[0] = 1'b1;
    op = 3'd1;
    a = 32'hDEAD_BEEF;
    b = 5'd0;
    sb.push_back('{32'hDEAD_BEEF, 1});
    @(posedge clk);
    #1;
    op = 3'd0;
    a = 32'h1234_5678;
    b = 5'd4;
    sb.push_back('{32'h2345_6780, 3});
    wait_done(0, "zero");
    wait_done(0, "b2b");
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_idle", {31'd0, busy[0]}, 32'd0);
    for (int d = 0; d < 4; d++)
      for (int o = 0; o < 8; o++)
        for (int n = 0; n < 32; n++) begin
          logic [31:0] x;
          x = $urandom;
          run_op(d, 3'(o), x, 5'(n), model(3'(o), x, 5'(n)), (n + step_of(d) - 1) / step_of(d) + 1, "sweep");
        end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
